// File: rtl/bd_rx_pkg.sv
// Shared definitions for the bd receive core: host register map, STATUS/CTRL bit
// positions and the deframer state encoding.
package bd_rx_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_THRESH = 8'h02;
   localparam logic [7:0] ADDR_RXDATA = 8'h03;
   localparam logic [7:0] ADDR_LEVEL  = 8'h04;
   localparam logic [7:0] ADDR_IRQLVL = 8'h05;

   localparam int CTRL_RX_EN    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_FIFO_CLR = 2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_FULL  = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_FERR  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

endpackage

// File: rtl/bd_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous clear. DEPTH must be a power of two >= 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bd_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bd_rx_core.sv
// Receive core: hysteresis slicer on oversampled ADC samples, UART-style deframer,
// receive FIFO and byte-wide host register map with a level interrupt. ADC_W <= 8.
module bd_rx_core
   import bd_rx_pkg::*;
#(
   parameter int ADC_W      = 8,
   parameter int DATA_W     = 8,
   parameter int OSR        = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int HYST       = 4
) (
   input  logic             G_CLK_RX,
   input  logic             reset,
   input  logic [ADC_W-1:0] ADC,
   input  logic [7:0]       ADDRESS,
   input  logic [7:0]       DATA_IN,
   input  logic             write_enable,
   input  logic             read_enable,
   output logic [7:0]       DATA_OUT,
   output logic             int_rx_host
);

   localparam int SW    = ADC_W + 1;
   localparam int CNT_W = $clog2(OSR);
   localparam int BIT_W = $clog2(DATA_W) + 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SW-1:0] ADC_MAX = {1'b0, {ADC_W{1'b1}}};

   // host-visible registers
   logic             rx_en;
   logic             irq_en;
   logic [ADC_W-1:0] thresh;
   logic [7:0]       irq_lvl;
   logic             overflow;
   logic             frame_err;

   // slicer and deframer
   logic             line;
   logic             line_d;
   logic [SW-1:0]    thr_sum;
   logic [SW-1:0]    thr_hi;
   logic [SW-1:0]    thr_lo;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W:0]  shift_ext;
   logic             word_push;
   logic             ferr_set;

   // fifo and bus
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_pop;
   logic              fifo_clr;
   logic              ovf_set;
   logic              wr_ctrl, wr_status, wr_thresh, wr_irqlvl;
   logic [7:0]        status_v;
   logic [7:0]        rd_mux;
   logic [7:0]        irq_eff;

   // Thresholds are computed one bit wider so they saturate instead of wrapping.
   assign thr_sum = {1'b0, thresh} + SW'(HYST);
   assign thr_hi  = (thr_sum > ADC_MAX) ? ADC_MAX : thr_sum;
   assign thr_lo  = ({1'b0, thresh} < SW'(HYST)) ? '0 : ({1'b0, thresh} - SW'(HYST));

   always_ff @(posedge G_CLK_RX or negedge reset) begin
      if (!reset) begin
         line   <= 1'b1;
         line_d <= 1'b1;
      end else begin
         line_d <= line;
         if ({1'b0, ADC} >= thr_hi)     line <= 1'b1;
         else if ({1'b0, ADC} < thr_lo) line <= 1'b0;
      end
   end

   assign shift_ext = {line, shift_q} >> 1;

   always_ff @(posedge G_CLK_RX or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      word_push = 1'b0;
      ferr_set  = 1'b0;
      if (!rx_en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A falling edge needs line_d=1, so after a bad stop bit we wait for idle high.
               if (line_d && !line) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_W'(OSR/2 - 1)) begin
                  cnt_d = '0;
                  bit_d = '0;
                  state_d = line ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_q == CNT_W'(OSR - 1)) begin
                  cnt_d   = '0;
                  shift_d = shift_ext[DATA_W-1:0];
                  if (bit_q == BIT_W'(DATA_W - 1)) state_d = ST_STOP;
                  else                             bit_d   = bit_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_q == CNT_W'(OSR - 1)) begin
                  cnt_d     = '0;
                  state_d   = ST_IDLE;
                  word_push = line;
                  ferr_set  = ~line;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign wr_ctrl   = write_enable && (ADDRESS == ADDR_CTRL);
   assign wr_status = write_enable && (ADDRESS == ADDR_STATUS);
   assign wr_thresh = write_enable && (ADDRESS == ADDR_THRESH);
   assign wr_irqlvl = write_enable && (ADDRESS == ADDR_IRQLVL);
   assign fifo_clr  = wr_ctrl && DATA_IN[CTRL_FIFO_CLR];
   assign fifo_pop  = read_enable && (ADDRESS == ADDR_RXDATA) && !fifo_empty;
   assign ovf_set   = word_push && fifo_full && !fifo_pop && !fifo_clr;
   assign irq_eff   = (irq_lvl == 8'd0) ? 8'd1 : irq_lvl;

   bd_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (G_CLK_RX),
      .rst_n (reset),
      .push  (word_push),
      .pop   (fifo_pop),
      .clear (fifo_clr),
      .wdata (shift_q),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      status_v             = '0;
      status_v[STAT_BUSY]  = (state_q != ST_IDLE);
      status_v[STAT_EMPTY] = fifo_empty;
      status_v[STAT_FULL]  = fifo_full;
      status_v[STAT_OVF]   = overflow;
      status_v[STAT_FERR]  = frame_err;
      rd_mux = '0;
      case (ADDRESS)
         ADDR_CTRL:   rd_mux = {6'b0, irq_en, rx_en};
         ADDR_STATUS: rd_mux = status_v;
         ADDR_THRESH: rd_mux = 8'(thresh);
         ADDR_RXDATA: rd_mux = fifo_empty ? 8'h00 : 8'(fifo_rdata);
         ADDR_LEVEL:  rd_mux = 8'(fifo_level);
         ADDR_IRQLVL: rd_mux = irq_lvl;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge G_CLK_RX or negedge reset) begin
      if (!reset) begin
         rx_en       <= 1'b0;
         irq_en      <= 1'b0;
         thresh      <= {1'b1, {(ADC_W-1){1'b0}}};
         irq_lvl     <= 8'd1;
         overflow    <= 1'b0;
         frame_err   <= 1'b0;
         DATA_OUT    <= '0;
         int_rx_host <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            rx_en  <= DATA_IN[CTRL_RX_EN];
            irq_en <= DATA_IN[CTRL_IRQ_EN];
         end
         if (wr_thresh) thresh  <= DATA_IN[ADC_W-1:0];
         if (wr_irqlvl) irq_lvl <= DATA_IN;
         // New events take priority over a simultaneous write-1-to-clear.
         overflow  <= ovf_set  | (overflow  & ~(wr_status & DATA_IN[STAT_OVF]));
         frame_err <= ferr_set | (frame_err & ~(wr_status & DATA_IN[STAT_FERR]));
         if (read_enable) DATA_OUT <= rd_mux;
         int_rx_host <= irq_en & ((8'(fifo_level) >= irq_eff) | overflow | frame_err);
      end
   end

endmodule

// File: tb/tb_bd_rx_core.sv
// Bench for bd_rx_core: register table at reset, framed traffic with a queue of
// expected words, overflow, interrupt threshold and slicer hysteresis sequences.
module tb_bd_rx_core;

   localparam int ADC_W      = 8;
   localparam int DATA_W     = 8;
   localparam int OSR        = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int HYST       = 4;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic [ADC_W-1:0] adc;
   logic [7:0]       address;
   logic [7:0]       data_in;
   logic             write_enable;
   logic             read_enable;
   logic [7:0]       data_out;
   logic             int_rx_host;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic       m_ovf  = 1'b0;
   logic       m_ferr = 1'b0;

   bd_rx_core #(
      .ADC_W      (ADC_W),
      .DATA_W     (DATA_W),
      .OSR        (OSR),
      .FIFO_DEPTH (FIFO_DEPTH),
      .HYST       (HYST)
   ) dut (
      .G_CLK_RX     (clk),
      .reset        (rst_n),
      .ADC          (adc),
      .ADDRESS      (address),
      .DATA_IN      (data_in),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .DATA_OUT     (data_out),
      .int_rx_host  (int_rx_host)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks: every task starts and ends just after a falling edge
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      address      = a;
      data_in      = d;
      write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
      address     = a;
      read_enable = 1'b1;
      @(negedge clk);
      read_enable = 1'b0;
      d           = data_out;
   endtask

   task automatic drive(input logic [ADC_W-1:0] v, input int n);
      repeat (n) begin
         adc = v;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_ok);
      drive(8'hFF, 2);
      drive(8'h00, OSR);
      for (int i = 0; i < DATA_W; i++) drive(d[i] ? 8'hFF : 8'h00, OSR);
      drive(stop_ok ? 8'hFF : 8'h00, OSR);
      drive(8'hFF, 4);
      if (!stop_ok)                         m_ferr = 1'b1;
      else if (exp_q.size() < FIFO_DEPTH)   exp_q.push_back(d);
      else                                  m_ovf = 1'b1;
   endtask

   function automatic logic [7:0] model_status();
      logic [7:0] s;
      s    = 8'h00;
      s[1] = (exp_q.size() == 0);
      s[2] = (exp_q.size() == FIFO_DEPTH);
      s[3] = m_ovf;
      s[4] = m_ferr;
      return s;
   endfunction

   // scoreboard side: pop the expected word when the host reads RXDATA
   task automatic read_word(input string name);
      logic [7:0] d;
      logic [7:0] e;
      e = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
      reg_read(8'h03, d);
      check(name, d, e);
   endtask

   task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] e);
      logic [7:0] d;
      reg_read(a, d);
      check(name, d, e);
   endtask

   initial begin
      vec_t rst_tab[8];
      logic [7:0] d;

      rst_tab[0] = '{8'h02, 8'h80};
      rst_tab[1] = '{8'h04, 8'h00};
      rst_tab[2] = '{8'h05, 8'h01};
      rst_tab[3] = '{8'h00, 8'h00};
      rst_tab[4] = '{8'h01, 8'h02};
      rst_tab[5] = '{8'h03, 8'h00};
      rst_tab[6] = '{8'h07, 8'h00};
      rst_tab[7] = '{8'hFF, 8'h00};

      rst_n = 1'b0; adc = 8'hFF; address = 8'h00; data_in = 8'h00;
      write_enable = 1'b0; read_enable = 1'b0;
      idle(3);
      check("reset data_out", data_out, 8'h00);
      check("reset int", int_rx_host, 1'b0);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 8; i++) begin
         reg_read(rst_tab[i].addr, d);
         check($sformatf("reset rd addr 0x%02h", rst_tab[i].addr), d, rst_tab[i].exp);
      end
      check("reset int after reads", int_rx_host, 1'b0);

      // single frame
      reg_write(8'h00, 8'h01);
      send_frame(8'hA5, 1'b1);
      check_reg("level after A5", 8'h04, 8'(exp_q.size()));
      read_word("rxdata A5");
      check_reg("level after pop", 8'h04, 8'h00);
      check_reg("status after pop", 8'h01, model_status());
      read_word("rxdata empty");

      // short low glitch from idle
      drive(8'h00, 3);
      adc = 8'hFF;
      check_reg("status busy in glitch", 8'h01, 8'h03);
      drive(8'hFF, 10);
      check_reg("status after glitch", 8'h01, model_status());
      check_reg("level after glitch", 8'h04, 8'h00);

      // bad stop bit
      send_frame(8'h3C, 1'b0);
      check_reg("status frame_err", 8'h01, model_status());
      check_reg("level after bad stop", 8'h04, 8'h00);
      reg_write(8'h01, 8'h10);
      m_ferr = 1'b0;
      check_reg("status after w1c ferr", 8'h01, model_status());

      // fill past depth
      for (int i = 0; i < FIFO_DEPTH + 1; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
      check_reg("status full+ovf", 8'h01, model_status());
      check_reg("level full", 8'h04, 8'(FIFO_DEPTH));
      for (int i = 0; i < FIFO_DEPTH; i++) read_word($sformatf("rxdata fill %0d", i));
      check_reg("status drained", 8'h01, model_status());
      reg_write(8'h01, 8'h08);
      m_ovf = 1'b0;
      check_reg("status after w1c ovf", 8'h01, model_status());

      // fifo clear
      send_frame(8'h5A, 1'b1);
      check_reg("level before clr", 8'h04, 8'h01);
      reg_write(8'h00, 8'h05);
      exp_q.delete();
      check_reg("level after clr", 8'h04, 8'h00);
      check_reg("ctrl clr reads 0", 8'h00, 8'h01);

      // interrupt threshold
      reg_write(8'h05, 8'h02);
      reg_write(8'h00, 8'h03);
      send_frame(8'h11, 1'b1);
      idle(2);
      check("int after 1st frame", int_rx_host, 1'b0);
      send_frame(8'h22, 1'b1);
      idle(2);
      check("int after 2nd frame", int_rx_host, 1'b1);
      read_word("rxdata irq 1");
      idle(2);
      check("int below level", int_rx_host, 1'b0);
      reg_write(8'h05, 8'h00);
      idle(2);
      check("int irqlvl 0 as 1", int_rx_host, 1'b1);
      read_word("rxdata irq 2");
      idle(2);
      check("int empty", int_rx_host, 1'b0);
      reg_write(8'h00, 8'h01);

      // hysteresis: line high must hold through THRESH-(HYST-1)
      for (int i = 0; i < 6; i++) begin
         adc = i[0] ? 8'h83 : 8'h7D;
         reg_read(8'h01, d);
         check($sformatf("busy hyst high %0d", i), d[0], 1'b0);
      end
      // line low must hold through THRESH+(HYST-1)
      reg_write(8'h00, 8'h00);
      drive(8'h00, 3);
      adc = 8'h83;
      reg_write(8'h00, 8'h01);
      for (int i = 0; i < 6; i++) begin
         adc = i[0] ? 8'h83 : 8'h7D;
         reg_read(8'h01, d);
         check($sformatf("busy hyst low %0d", i), d[0], 1'b0);
      end
      // exact boundaries: THRESH+HYST sets, THRESH-HYST-1 clears
      drive(8'h84, 2);
      adc = 8'h7B;
      idle(2);
      reg_read(8'h01, d);
      check("busy at thr_lo edge", d, 8'h03);
      drive(8'hFF, 10);
      check_reg("status after boundary", 8'h01, model_status());
      check_reg("level final", 8'h04, 8'(exp_q.size()));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
